// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: decode-side control, instruction-memory handshake and IF/ID outputs.
// The master modport is taken by instr_fetch; the slave side belongs to memory/decode.
interface instr_fetch_if;
    logic        iStall;
    logic        iBranch;
    logic        iUBranch;
    logic        iZero;
    logic [63:0] iBranchTarget;
    logic        oIMemReq;
    logic [63:0] oIMemAddr;
    logic        iIMemAck;
    logic [31:0] iIMemData;
    logic [31:0] oInstr;
    logic [63:0] oPC;
    logic        oValid;
    logic [10:0] oOp;

    modport master (
        input  iStall, iBranch, iUBranch, iZero, iBranchTarget, iIMemAck, iIMemData,
        output oIMemReq, oIMemAddr, oInstr, oPC, oValid, oOp
    );

    modport slave (
        output iStall, iBranch, iUBranch, iZero, iBranchTarget, iIMemAck, iIMemData,
        input  oIMemReq, oIMemAddr, oInstr, oPC, oValid, oOp
    );
endinterface

// File: rtl/instr_fetch.sv
// LEGv8 instruction-fetch stage: PC, variable-latency imem handshake, IF/ID register,
// one-entry skid buffer for decode stalls, and branch redirect with in-flight drop.
module instr_fetch #(
    parameter logic [63:0] PcReset = 64'h0000_0000_0040_0000
) (
    input logic           iCLK,
    input logic           iRST,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StFull, StDrop} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] pcn_q, pcn_d;
    logic [63:0] ipc_q, ipc_d;
    logic [63:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [63:0] target;
    logic        req;
    logic        take;
    logic        hold;

    assign redirect = bus.iUBranch | (bus.iBranch & bus.iZero);
    assign target   = bus.iBranchTarget & ~64'h3;
    assign hold     = bus.iStall & valid_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (bus.iIMemAck) begin
                    if (!redirect && hold) state_d = StFull;
                end else if (redirect) begin
                    state_d = StDrop;
                end
            end
            StFull: if (redirect || !bus.iStall) state_d = StReq;
            StDrop: if (bus.iIMemAck) state_d = StReq;
            default: state_d = StIdle;
        endcase
    end

    // take: a memory word is accepted this cycle (ack only counts while requesting)
    always_comb begin
        req  = 1'b0;
        take = 1'b0;
        unique case (state_q)
            StReq: begin
                req  = 1'b1;
                take = bus.iIMemAck;
            end
            StDrop:  req = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        pcn_d        = pcn_q;
        ipc_d        = ipc_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        // IF/ID: redirect flushes, stall holds, otherwise load a new word or bubble
        if (redirect) begin
            valid_d = 1'b0;
            instr_d = 32'h0;
            ipc_d   = 64'h0;
        end else if (hold) begin
            if (take) begin
                skid_instr_d = bus.iIMemData;
                skid_pc_d    = pc_q;
            end
        end else if (take) begin
            valid_d = 1'b1;
            instr_d = bus.iIMemData;
            ipc_d   = pc_q;
        end else if (state_q == StFull) begin
            valid_d = 1'b1;
            instr_d = skid_instr_q;
            ipc_d   = skid_pc_q;
        end else begin
            valid_d = 1'b0;
            instr_d = 32'h0;
            ipc_d   = 64'h0;
        end

        unique case (state_q)
            StIdle: if (redirect) pc_d = target;
            StReq: begin
                if (bus.iIMemAck) pc_d = redirect ? target : pc_q + 64'd4;
                else if (redirect) pcn_d = target;
            end
            StFull: begin
                if (redirect) begin
                    pc_d         = target;
                    skid_pc_d    = 64'h0;
                    skid_instr_d = 32'h0;
                end
            end
            StDrop: begin
                // the address stays on the bus until the abandoned request completes
                if (bus.iIMemAck) pc_d = redirect ? target : pcn_q;
                else if (redirect) pcn_d = target;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pc_q         <= PcReset;
            pcn_q        <= PcReset;
            ipc_q        <= 64'h0;
            instr_q      <= 32'h0;
            valid_q      <= 1'b0;
            skid_pc_q    <= 64'h0;
            skid_instr_q <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            pcn_q        <= pcn_d;
            ipc_q        <= ipc_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign bus.oIMemReq  = req;
    assign bus.oIMemAddr = pc_q;
    assign bus.oInstr    = instr_q;
    assign bus.oPC       = ipc_q;
    assign bus.oValid    = valid_q;
    assign bus.oOp       = instr_q[31:21];

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the LEGv8 processor, directly upstream of the main control decoder. It owns the program counter and issues requests to the instruction memory over a variable-latency request/acknowledge handshake. Fetched words are held in an IF/ID register whose opcode field drives the decoder's 11-bit opcode input. The stage honours decode stalls through a one-entry skid buffer and flushes on taken branches.

## Interface
- PC_RESET, 64'h0000_0000_0040_0000, PC value loaded on reset.
- iCLK  in  1  clock; all state changes on its rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iStall  in  1  decode cannot accept; hold IF/ID.
- iBranch  in  1  conditional branch (CBZ) resolved this cycle.
- iUBranch  in  1  unconditional branch (B/BL/BR) resolved this cycle.
- iZero  in  1  ALU zero flag for the CBZ condition.
- iBranchTarget  in  64  redirect address.
- oIMemReq  out  1  instruction-memory request.
- oIMemAddr  out  64  request address.
- iIMemAck  in  1  memory returns data this cycle.
- iIMemData  in  32  instruction word, valid with iIMemAck.
- oInstr  out  32  IF/ID instruction.
- oPC  out  64  IF/ID PC of oInstr.
- oValid  out  1  IF/ID holds a live instruction.
- oOp  out  11  oInstr[31:21], feeds the control decoder opcode; combinational from the IF/ID register.

## Operation
- Redirect = iUBranch | (iBranch & iZero). Target is iBranchTarget with bits [1:0] forced to 00.
- Sequential PC = PC + 4, modulo 2^64 (wraps silently).
- States:
  - S_IDLE: reset state, no request.
  - S_REQ: request outstanding.
  - S_FULL: skid buffer occupied, request low.
  - S_DROP: outstanding request will be discarded.
- S_IDLE -> S_REQ unconditionally on the first edge after reset release.
- S_REQ, with oIMemReq = 1 and oIMemAddr = PC held stable until ack:
  - Ack, no redirect, slot free (!oValid | !iStall): load IF/ID with {iIMemData, PC}, set oValid = 1, PC += 4, stay in S_REQ.
  - Ack, no redirect, iStall & oValid: capture the word and its PC in the skid buffer, PC += 4, go to S_FULL.
  - Ack with redirect: discard data, PC = target, stay in S_REQ.
  - No ack with redirect: latch target into PC_next, go to S_DROP.
- S_FULL, oIMemReq = 0:
  - !iStall: IF/ID loads the skid entry, go to S_REQ.
  - Redirect: clear the skid entry, PC = target, go to S_REQ.
- S_DROP: oIMemReq = 1 with the old address. On ack, discard data, PC = PC_next, go to S_REQ. A further redirect while in S_DROP overwrites PC_next.
- Redirect always flushes IF/ID (oValid = 0 next edge) and has priority over iStall.
- While iStall & oValid and no redirect: oInstr, oPC and oValid hold.
- !iStall with no new word: oValid = 0 next edge (bubble). When oValid = 0, oInstr = 0, which the decoder treats as unrecognised (all controls 0).

## Timing
- Reset, asynchronous, takes effect immediately: PC = PC_RESET, state S_IDLE, oIMemReq = 0, oIMemAddr = PC_RESET, oValid = 0, oInstr = 0, oPC = 0, oOp = 0, skid empty.
- Reset asserted mid-transaction abandons any outstanding request. The memory must tolerate a request dropping without ack.
- First request is visible 1 cycle after reset release.
- With zero-wait memory (ack in the same cycle as the request), throughput is 1 instruction/cycle. Latency from the ack edge to oValid = 1 is 1 cycle.
- iIMemAck is ignored unless oIMemReq = 1.
- Redirect-to-first-fetch of the target:
  - 1 cycle when no request is outstanding or the ack arrives with the redirect.
  - Otherwise, 1 cycle after the dropped request's ack.

## Test plan
- Reset release with memory acking every cycle with data = address[31:0]: oIMemAddr reads 0x400000, 0x400004, 0x400008. oValid rises 2 cycles after release. oOp = oInstr[31:21].
- Two-cycle memory latency: oIMemAddr stays stable through the wait cycles. One instruction is delivered per 2 cycles, with no duplicates or skips.
- iStall held 3 cycles while an ack arrives: IF/ID holds, the skid captures the word, and oIMemReq drops. After the stall, the buffered word appears, then fetch resumes at the next sequential address.
- iUBranch pulse, target 0x401003, with no ack pending: IF/ID is flushed and the next request goes to 0x401000. With the ack in flight (S_DROP), the returned data never reaches oInstr.
- iBranch = 1 with iZero = 0: no redirect, and the sequence continues at PC + 4. Separately, PC = 64'hFFFF_FFFF_FFFF_FFFC fetches next at 0.
- iRST asserted mid-wait in S_REQ: all outputs return to their reset values immediately, and the next request is to PC_RESET after release.
